ir_camera_tracker: RTL and testbench

- Parametrised multi-blob controller for the PixArt IR camera (1024x768, I2C address 7'h58), next generation of the single-point camera reader.
- Runs the configuration write sequence, then polls the 16-byte extended-mode report and decodes up to NUM_BLOBS blobs into X, Y and size.
- Sits between the existing i2c_master (handshake ports exposed here, master instantiated by parent) and the position/drawing logic.
- Adds per-blob visibility flags, a frame strobe and a bus-hang watchdog with automatic re-initialisation.

---
 rtl/ir_camera_tracker.sv | 232 +++++++++++++++++++++++
 tb/tb_ir_camera_tracker.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ir_camera_tracker.sv
// Multi-blob controller for the PixArt IR camera: configures the sensor through
// an external i2c_master, polls the extended-mode report and decodes blobs.
module ir_camera_tracker #(
    parameter int unsigned            NUM_BLOBS   = 4,
    parameter int unsigned            CONF_PAIRS  = 3,
    parameter logic [16*CONF_PAIRS-1:0] CONF_DATA = 48'h300130083333,
    parameter int unsigned            START_DELAY = 200,
    parameter int unsigned            CONF_DELAY  = 100,
    parameter int unsigned            POLL_DELAY  = 100,
    parameter int unsigned            TIMEOUT     = 4095
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      clk_en,
    output logic                      i2c_start,
    output logic                      i2c_rw,
    output logic [4:0]                i2c_packets,
    output logic [7:0]                i2c_data,
    input  logic                      i2c_data_req,
    input  logic [7:0]                i2c_data_in,
    input  logic                      i2c_data_ready,
    input  logic                      i2c_ready,
    output logic [10*NUM_BLOBS-1:0]   blob_x,
    output logic [10*NUM_BLOBS-1:0]   blob_y,
    output logic [4*NUM_BLOBS-1:0]    blob_size,
    output logic [NUM_BLOBS-1:0]      blob_valid,
    output logic                      frame_valid,
    output logic                      configured,
    output logic                      timeout_err
);

    localparam int unsigned CNT_W    = 12;
    localparam int unsigned RD_W     = 5;
    localparam int unsigned PAIR_W   = (CONF_PAIRS > 1) ? $clog2(CONF_PAIRS) : 1;
    localparam int unsigned RPT_USED = 3 * NUM_BLOBS;

    typedef enum logic [3:0] {
        ST_START, ST_START_WAIT, ST_CONF, ST_CONF_WAIT, ST_CONF_DELAY,
        ST_REQ_ADDR, ST_REQ_ADDR_WAIT, ST_READ, ST_READ_WAIT,
        ST_PROCESS, ST_POLL_WAIT
    } state_t;

    state_t                  state_q, state_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [PAIR_W-1:0]       pair_q, pair_d;
    logic [1:0]              bsel_q, bsel_d;
    logic [RD_W-1:0]         rd_cnt_q, rd_cnt_d;
    logic [7:0]              rpt_q [1:RPT_USED];
    logic [7:0]              rpt_d [1:RPT_USED];
    logic                    start_d, rw_d, fv_d, cfg_d, terr_d;
    logic [4:0]              pk_d;
    logic [7:0]              data_d, conf_byte;
    logic [10*NUM_BLOBS-1:0] bx_d, by_d;
    logic [4*NUM_BLOBS-1:0]  bs_d;
    logic [NUM_BLOBS-1:0]    bv_d;
    logic                    wd_expired, wd_fire;
    logic [9:0]              dec_x, dec_y;

    // Select the configuration byte for the current pair/byte position (first write in MSBs)
    always_comb begin
        conf_byte = '0;
        for (int i = 0; i < int'(2 * CONF_PAIRS); i++) begin
            if (i == 2 * int'(pair_q) + int'(bsel_q[0]))
                conf_byte = CONF_DATA[8*(2*int'(CONF_PAIRS)-i)-1 -: 8];
        end
    end

    // Next-state, counters, report capture, decode and output values
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        pair_d     = pair_q;
        bsel_d     = bsel_q;
        rd_cnt_d   = rd_cnt_q;
        rpt_d      = rpt_q;
        start_d    = i2c_start;
        rw_d       = i2c_rw;
        pk_d       = i2c_packets;
        data_d     = i2c_data;
        bx_d       = blob_x;
        by_d       = blob_y;
        bs_d       = blob_size;
        bv_d       = blob_valid;
        fv_d       = 1'b0;
        cfg_d      = configured;
        terr_d     = timeout_err;
        wd_fire    = 1'b0;
        dec_x      = '0;
        dec_y      = '0;
        wd_expired = (cnt_q == CNT_W'(TIMEOUT - 1));
        if (clk_en) begin
            cnt_d = cnt_q + 1'b1;
            unique case (state_q)
                ST_START: if (i2c_ready) state_d = ST_START_WAIT;
                ST_START_WAIT: begin
                    if (cnt_q == CNT_W'(START_DELAY - 1)) begin
                        state_d = ST_CONF;
                        pair_d  = '0;
                    end
                end
                ST_CONF: begin
                    start_d = 1'b1;
                    rw_d    = 1'b0;
                    pk_d    = 5'd2;
                    bsel_d  = '0;
                    if (!i2c_ready) begin
                        start_d = 1'b0;
                        state_d = ST_CONF_WAIT;
                    end
                end
                ST_CONF_WAIT: begin
                    if (i2c_data_req && bsel_q < 2'd2) begin
                        data_d = conf_byte;
                        bsel_d = bsel_q + 1'b1;
                    end
                    if (i2c_ready)       state_d = ST_CONF_DELAY;
                    else if (wd_expired) wd_fire = 1'b1;
                end
                ST_CONF_DELAY: begin
                    if (cnt_q == CNT_W'(CONF_DELAY - 1)) begin
                        if (pair_q == PAIR_W'(CONF_PAIRS - 1)) begin
                            cfg_d   = 1'b1;
                            state_d = ST_REQ_ADDR;
                        end else begin
                            pair_d  = pair_q + 1'b1;
                            state_d = ST_CONF;
                        end
                    end
                end
                ST_REQ_ADDR: begin
                    start_d = 1'b1;
                    rw_d    = 1'b0;
                    pk_d    = 5'd1;
                    data_d  = 8'h36;
                    state_d = ST_REQ_ADDR_WAIT;
                end
                ST_REQ_ADDR_WAIT: begin
                    start_d = 1'b0;
                    if (i2c_ready && !i2c_start) state_d = ST_READ;
                    else if (wd_expired)         wd_fire = 1'b1;
                end
                ST_READ: begin
                    start_d  = 1'b1;
                    rw_d     = 1'b1;
                    pk_d     = 5'd16;
                    rd_cnt_d = '0;
                    state_d  = ST_READ_WAIT;
                end
                ST_READ_WAIT: begin
                    start_d = 1'b0;
                    // Byte is stored before the ready check so a same-tick finish counts it
                    if (i2c_data_ready && rd_cnt_q < 5'd16) begin
                        for (int k = 1; k <= int'(RPT_USED); k++) begin
                            if (rd_cnt_q == RD_W'(k)) rpt_d[k] = i2c_data_in;
                        end
                        rd_cnt_d = rd_cnt_q + 1'b1;
                    end
                    if (i2c_ready && !i2c_start && rd_cnt_d != '0) state_d = ST_PROCESS;
                    else if (wd_expired)                           wd_fire = 1'b1;
                end
                ST_PROCESS: begin
                    fv_d = 1'b1;
                    for (int n = 0; n < int'(NUM_BLOBS); n++) begin
                        if (rd_cnt_q >= RD_W'(4 + 3*n)) begin
                            dec_x            = {rpt_q[3+3*n][5:4], rpt_q[1+3*n]};
                            dec_y            = {rpt_q[3+3*n][7:6], rpt_q[2+3*n]};
                            bx_d[10*n +: 10] = dec_x;
                            by_d[10*n +: 10] = dec_y;
                            bs_d[4*n +: 4]   = rpt_q[3+3*n][3:0];
                            bv_d[n]          = (dec_x != 10'h3FF) && (dec_y != 10'h3FF);
                        end else begin
                            bv_d[n] = 1'b0;
                        end
                    end
                    state_d = ST_POLL_WAIT;
                end
                ST_POLL_WAIT: if (cnt_q == CNT_W'(POLL_DELAY - 1)) state_d = ST_REQ_ADDR;
                default: state_d = ST_START;
            endcase
            // Bus hang: abandon the transaction and run the full configuration again
            if (wd_fire) begin
                state_d = ST_START;
                terr_d  = 1'b1;
                cfg_d   = 1'b0;
                start_d = 1'b0;
            end
            if (state_d != state_q) cnt_d = '0;
        end
    end

    // State and output registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_START;
            cnt_q       <= '0;
            pair_q      <= '0;
            bsel_q      <= '0;
            rd_cnt_q    <= '0;
            for (int k = 1; k <= int'(RPT_USED); k++) rpt_q[k] <= '0;
            i2c_start   <= 1'b0;
            i2c_rw      <= 1'b1;
            i2c_packets <= '0;
            i2c_data    <= '0;
            blob_x      <= '1;
            blob_y      <= '1;
            blob_size   <= '0;
            blob_valid  <= '0;
            frame_valid <= 1'b0;
            configured  <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            pair_q      <= pair_d;
            bsel_q      <= bsel_d;
            rd_cnt_q    <= rd_cnt_d;
            rpt_q       <= rpt_d;
            i2c_start   <= start_d;
            i2c_rw      <= rw_d;
            i2c_packets <= pk_d;
            i2c_data    <= data_d;
            blob_x      <= bx_d;
            blob_y      <= by_d;
            blob_size   <= bs_d;
            blob_valid  <= bv_d;
            frame_valid <= fv_d;
            configured  <= cfg_d;
            timeout_err <= terr_d;
        end
    end

endmodule

// File: tb/tb_ir_camera_tracker.sv
// Directed bench for ir_camera_tracker with a behavioural i2c_master model.
module tb_ir_camera_tracker;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        clk_en;
    logic        i2c_start, i2c_rw;
    logic [4:0]  i2c_packets;
    logic [7:0]  i2c_data;
    logic        i2c_data_req = 1'b0;
    logic [7:0]  i2c_data_in = 8'h00;
    logic        i2c_data_ready = 1'b0;
    logic        i2c_ready = 1'b1;
    logic [39:0] blob_x, blob_y;
    logic [15:0] blob_size;
    logic [3:0]  blob_valid;
    logic        frame_valid, configured, timeout_err;

    int n_tests = 0;
    int n_fail  = 0;

    // Master model state and transaction logs
    int         m_st = 0, m_ph = 0, m_left = 0, m_idx = 0;
    int         rd_limit = 16;
    bit         m_hang = 1'b0;
    logic [7:0] rd_bytes [16];
    logic [7:0] wlog [$];
    logic       st_rw [$];
    logic [4:0] st_pk [$];
    logic [7:0] cfg_exp [6];

    ir_camera_tracker dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .clk_en         (clk_en),
        .i2c_start      (i2c_start),
        .i2c_rw         (i2c_rw),
        .i2c_packets    (i2c_packets),
        .i2c_data       (i2c_data),
        .i2c_data_req   (i2c_data_req),
        .i2c_data_in    (i2c_data_in),
        .i2c_data_ready (i2c_data_ready),
        .i2c_ready      (i2c_ready),
        .blob_x         (blob_x),
        .blob_y         (blob_y),
        .blob_size      (blob_size),
        .blob_valid     (blob_valid),
        .frame_valid    (frame_valid),
        .configured     (configured),
        .timeout_err    (timeout_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Behavioural i2c master: reacts on the falling edge so the DUT samples stable inputs
    always @(negedge clk) begin
        i2c_data_req   = 1'b0;
        i2c_data_ready = 1'b0;
        if (!reset_n) begin
            m_st      = 0;
            i2c_ready = 1'b1;
        end else begin
            case (m_st)
                0: if (i2c_start && i2c_ready) begin
                    i2c_ready = 1'b0;
                    st_rw.push_back(i2c_rw);
                    st_pk.push_back(i2c_packets);
                    m_ph  = 0;
                    m_idx = 0;
                    if (i2c_rw) begin m_st = 2; m_left = rd_limit; end
                    else begin m_st = 1; m_left = int'(i2c_packets); end
                end
                1: begin
                    m_ph++;
                    if (m_ph == 1) i2c_data_req = 1'b1;
                    else begin
                        wlog.push_back(i2c_data);
                        m_left--;
                        m_ph = 0;
                        if (m_left <= 0) begin i2c_ready = 1'b1; m_st = 0; end
                    end
                end
                2: begin
                    m_ph++;
                    if (m_ph == 1) begin
                        if (m_idx < m_left) begin
                            i2c_data_in    = rd_bytes[m_idx];
                            i2c_data_ready = 1'b1;
                            m_idx++;
                        end
                    end else begin
                        m_ph = 0;
                        if (m_idx >= m_left) begin
                            if (m_hang) m_st = 3;
                            else begin i2c_ready = 1'b1; m_st = 0; end
                        end
                    end
                end
                3: if (!m_hang) begin i2c_ready = 1'b1; m_st = 0; end
                default: m_st = 0;
            endcase
        end
    end

    // Absolute time limit
    initial begin
        #1_000_000;
        $display("FAIL global_time_limit: observed running expected finished");
        $fatal(1, "time limit");
    end

    initial begin
        int w;
        cfg_exp = '{8'h30, 8'h01, 8'h30, 8'h08, 8'h33, 8'h33};
        clk_en  = 1'b1;
        reset_n = 1'b0;
        for (int i = 0; i < 16; i++) rd_bytes[i] = 8'hFF;
        rd_bytes[1] = 8'h10; rd_bytes[2] = 8'h20; rd_bytes[3] = 8'b1001_0101;
        repeat (3) @(negedge clk);

        // Reset values
        chk("rst_start",   64'(i2c_start), 64'(0));
        chk("rst_rw",      64'(i2c_rw), 64'(1));
        chk("rst_packets", 64'(i2c_packets), 64'(0));
        chk("rst_data",    64'(i2c_data), 64'(0));
        chk("rst_blob_x",  64'(blob_x), 64'(40'hFF_FFFF_FFFF));
        chk("rst_blob_y",  64'(blob_y), 64'(40'hFF_FFFF_FFFF));
        chk("rst_size",    64'(blob_size), 64'(0));
        chk("rst_valid",   64'(blob_valid), 64'(0));
        chk("rst_frame",   64'(frame_valid), 64'(0));
        chk("rst_cfg",     64'(configured), 64'(0));
        chk("rst_terr",    64'(timeout_err), 64'(0));
        reset_n = 1'b1;

        // Configuration: three two-byte writes, configured only after the last delay
        w = 0;
        while (wlog.size() < 6 && w < 3000) begin @(negedge clk); w++; end
        chk("cfg_write_count", 64'(wlog.size()), 64'(6));
        chk("cfg_low_before_delay", 64'(configured), 64'(0));
        w = 0;
        while (!configured && w < 1000) begin @(negedge clk); w++; end
        chk("cfg_up", 64'(configured), 64'(1));
        chk("cfg_delay_len", 64'(w >= 100), 64'(1));
        for (int i = 0; i < 6; i++) chk($sformatf("cfg_byte%0d", i), 64'(wlog[i]), 64'(cfg_exp[i]));
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("cfg_pk%0d", i), 64'(st_pk[i]), 64'(2));
            chk($sformatf("cfg_rw%0d", i), 64'(st_rw[i]), 64'(0));
        end

        // Frame 1: address write, 16-byte read, single visible blob
        w = 0;
        while (!frame_valid && w < 3000) begin @(negedge clk); w++; end
        chk("frame1_seen", 64'(frame_valid), 64'(1));
        clk_en = 1'b0;
        chk("addr_pk",   64'(st_pk[3]), 64'(1));
        chk("addr_rw",   64'(st_rw[3]), 64'(0));
        chk("addr_byte", 64'(wlog[6]), 64'(8'h36));
        chk("read_pk",   64'(st_pk[4]), 64'(16));
        chk("read_rw",   64'(st_rw[4]), 64'(1));
        chk("f1_x",     64'(blob_x), 64'({10'h3FF, 10'h3FF, 10'h3FF, 10'h110}));
        chk("f1_y",     64'(blob_y), 64'({10'h3FF, 10'h3FF, 10'h3FF, 10'h220}));
        chk("f1_size",  64'(blob_size), 64'(16'hFFF5));
        chk("f1_valid", 64'(blob_valid), 64'(4'b0001));
        @(negedge clk);
        chk("f1_pulse_one_clk", 64'(frame_valid), 64'(0));

        // clk_en low freezes the poll timer
        repeat (300) @(negedge clk);
        chk("freeze_no_txn", 64'(st_pk.size()), 64'(5));
        chk("freeze_start_low", 64'(i2c_start), 64'(0));

        // Frame 2: mix of visible/invisible blobs and zero coordinates
        rd_bytes[1] = 8'h00; rd_bytes[2]  = 8'h00; rd_bytes[3]  = 8'h00;
        rd_bytes[4] = 8'hFF; rd_bytes[5]  = 8'h00; rd_bytes[6]  = 8'b0011_0111;
        rd_bytes[7] = 8'h7F; rd_bytes[8]  = 8'hFF; rd_bytes[9]  = 8'b0110_1010;
        rd_bytes[10] = 8'h12; rd_bytes[11] = 8'h34; rd_bytes[12] = 8'b1101_1100;
        clk_en = 1'b1;
        w = 0;
        while (!frame_valid && w < 3000) begin @(negedge clk); w++; end
        chk("frame2_seen", 64'(frame_valid), 64'(1));
        chk("f2_x",     64'(blob_x), 64'({10'h112, 10'h27F, 10'h3FF, 10'h000}));
        chk("f2_y",     64'(blob_y), 64'({10'h334, 10'h1FF, 10'h000, 10'h000}));
        chk("f2_size",  64'(blob_size), 64'(16'hCA70));
        chk("f2_valid", 64'(blob_valid), 64'(4'b1101));

        // Frame 3: short read of 5 bytes, only blob 0 refreshed
        rd_bytes[1] = 8'h40; rd_bytes[2] = 8'h41; rd_bytes[3] = 8'b0001_0010; rd_bytes[4] = 8'h55;
        rd_limit = 5;
        @(negedge clk);
        w = 0;
        while (!frame_valid && w < 3000) begin @(negedge clk); w++; end
        chk("frame3_seen", 64'(frame_valid), 64'(1));
        chk("f3_x",     64'(blob_x), 64'({10'h112, 10'h27F, 10'h3FF, 10'h140}));
        chk("f3_y",     64'(blob_y), 64'({10'h334, 10'h1FF, 10'h000, 10'h041}));
        chk("f3_size",  64'(blob_size), 64'(16'hCA72));
        chk("f3_valid", 64'(blob_valid), 64'(4'b0001));

        // Watchdog: master never returns to ready during the read
        rd_limit = 16;
        m_hang   = 1'b1;
        w = 0;
        while (m_st != 3 && w < 3000) begin @(negedge clk); w++; end
        chk("hang_reached", 64'(m_st == 3), 64'(1));
        repeat (3900) @(negedge clk);
        chk("terr_not_early", 64'(timeout_err), 64'(0));
        w = 0;
        while (!timeout_err && w < 400) begin @(negedge clk); w++; end
        chk("terr_set",       64'(timeout_err), 64'(1));
        chk("terr_cfg_clear", 64'(configured), 64'(0));
        chk("terr_start_low", 64'(i2c_start), 64'(0));
        chk("terr_hold_x",    64'(blob_x), 64'({10'h112, 10'h27F, 10'h3FF, 10'h140}));
        wlog.delete();
        m_hang = 1'b0;
        w = 0;
        while (wlog.size() < 2 && w < 1000) begin @(negedge clk); w++; end
        chk("reconf_b0", 64'(wlog[0]), 64'(8'h30));
        chk("reconf_b1", 64'(wlog[1]), 64'(8'h01));
        chk("terr_sticky", 64'(timeout_err), 64'(1));

        // Asynchronous reset in the middle of a read
        w = 0;
        while (m_st != 2 && w < 3000) begin @(negedge clk); w++; end
        chk("midread_reached", 64'(m_st == 2), 64'(1));
        #2 reset_n = 1'b0;
        #1;
        chk("arst_blob_x", 64'(blob_x), 64'(40'hFF_FFFF_FFFF));
        chk("arst_valid",  64'(blob_valid), 64'(0));
        chk("arst_size",   64'(blob_size), 64'(0));
        chk("arst_terr",   64'(timeout_err), 64'(0));
        chk("arst_rw",     64'(i2c_rw), 64'(1));
        chk("arst_start",  64'(i2c_start), 64'(0));
        repeat (3) @(negedge clk);
        wlog.delete();
        st_pk.delete();
        st_rw.delete();
        reset_n = 1'b1;
        w = 0;
        while (wlog.size() < 6 && w < 3000) begin @(negedge clk); w++; end
        chk("rerun_write_count", 64'(wlog.size()), 64'(6));
        for (int i = 0; i < 6; i++) chk($sformatf("rerun_byte%0d", i), 64'(wlog[i]), 64'(cfg_exp[i]));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
